instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
// - Inverse of the ASIP control decoder: accepts instruction fields over a valid/ready stream.
// - Packs them into the 17-bit ASIP instruction word (type, I/L/B, cmd/cond, 11-bit operand).
// - Writes each packed word sequentially into instruction memory through a registered write port.
// - Sits between the host/boot program source and IMEM; the core is held in reset until done=1.
// PARAMETERS
// - ADDR_W   8    IMEM address width
// - DEPTH    256  number of IMEM words writable; DEPTH <= 2**ADDR_W
// PORTS
// - clk           in   1       single clock, rising edge
// - reset         in   1       asynchronous, active-high
// - start         in   1       1-cycle pulse: clear address/flags, enter LOAD
// - in_valid      in   1       field tuple valid
// - in_ready      out  1       block can accept tuple this cycle
// - in_tipo       in   2       00 data, 01 memory, 10 branch, 11 illegal
// - in_i          in   1       data: immediate-Src2 flag
// - in_cmd        in   2       data: 00 SUM/MOV, 01 RST, 10 COM, 11 illegal
// - in_l          in   1       memory: 1 LDR, 0 STR
// - in_b          in   1       branch: B bit
// - in_cond       in   3       branch: condition field
// - in_operand    in   11      raw operand/immediate/offset bits [10:0]
// - in_last       in   1       tuple is final instruction of program
// - imem_we       out  1       IMEM write strobe
// - imem_addr     out  ADDR_W  IMEM write address
// - imem_wdata    out  17      packed instruction word
// - count         out  ADDR_W+1 words written since start
// - busy          out  1       state == LOAD
// - done          out  1       state == DONE (sticky until start/reset)
// - err_illegal   out  1       sticky: an illegal tuple was dropped
// - err_overflow  out  1       sticky: tuple offered after DEPTH words written
// BEHAVIOUR
// - Reset: state IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0,
//   busy=0, done=0, err_illegal=0, err_overflow=0. Reset mid-load aborts immediately; IMEM content undefined.
// - FSM IDLE -> LOAD on start. LOAD -> DONE when a tuple with in_last=1 is accepted (legal or illegal).
//   LOAD -> DONE when count reaches DEPTH. DONE -> LOAD on start. start in LOAD restarts: address/count/errors cleared.
// - in_ready = (state==LOAD) && (count < DEPTH). Accept = in_valid && in_ready.
// - Packing (wdata[16:15]=in_tipo, wdata[10:0]=in_operand):
//   - 00: [14]=in_i, [13:12]=in_cmd, [11]=0
//   - 01: [14:13]=00, [12]=in_l, [11]=0
//   - 10: [14]=in_b, [13:11]=in_cond
//   - Unused-by-type inputs are ignored.
// - Illegal = tipo==11, or tipo==00 with cmd==11. Illegal tuples are accepted (in_ready honoured),
//   not written; count/address unchanged; err_illegal set next cycle.
// - Latency: legal tuple accepted on edge N -> imem_we=1 with addr/wdata valid for exactly the cycle after N.
//   Back-to-back accepts produce back-to-back writes, addr incrementing by 1.
// - imem_addr holds the address of the word being written; the internal pointer increments after each write.
//   count increments in the same cycle imem_we is asserted.
// - Full: once count==DEPTH, in_ready=0, no wraparound. in_valid=1 in that cycle (still LOAD, or DONE via full)
//   sets err_overflow. A tuple in IDLE/DONE without full is ignored, no error.
// - start coincident with in_valid: start wins; tuple not accepted that cycle.
// - done rises the cycle after the final write (or the illegal last-tuple accept).
// STRUCTURE
// - Shared package asip_isa_pkg: tipo_t enum (DATA=00, MEM=01, BRANCH=10), alu_cmd_t (SUM=00, RST=01, COM=10),
//   field bit-position constants, INSTR_W=17. The control decoder imports the same package.
// - Sub-module instr_packer: purely combinational fields -> {word, illegal}. Reused by the bench as reference model.
// - Top holds FSM, address pointer, count, output register, sticky flags.
// TESTING
// - Reset then start, ADD-imm (tipo00,i=1,cmd=00,op=0x005) -> 1 cycle later we=1, addr=0, wdata=17'h04005.
// - Stream LDR(l=1,op=0x010), STR(l=0,op=0x020), B(b=1,cond=3'b101,op=0x7FF,last=1) back-to-back
//   -> addr 0,1,2; wdata 17'h09010, 17'h08020, 17'h16FFF; done=1 next cycle, count=3.
// - tipo=11, then tipo=00/cmd=11 -> no we, count=0, err_illegal=1; next legal word lands at addr 0.
// - DEPTH=4, offer 5 tuples -> 4 writes, in_ready low after 4th, state DONE, err_overflow=1, no write to addr 0 again.
// - Assert reset during 3rd write of a 6-word load -> all outputs zero next sample; start reloads from addr 0.
// - start pulsed with in_valid=1 in DONE -> tuple ignored, count cleared to 0, done=0, busy=1.

Source files
------------

// File: rtl/asip_isa_pkg.sv
// ============================================================================
// asip_isa_pkg : ASIP instruction-word field layout shared by encoder and decoder
// Revision     : 1.0
// ============================================================================
`default_nettype none

package asip_isa_pkg;

  localparam int unsigned INSTR_W = 17;
  localparam int unsigned OP_W    = 11;

  typedef enum logic [1:0] {
    TIPO_DATA   = 2'b00,
    TIPO_MEM    = 2'b01,
    TIPO_BRANCH = 2'b10
  } tipo_t;

  typedef enum logic [1:0] {
    ALU_SUM = 2'b00,
    ALU_RST = 2'b01,
    ALU_COM = 2'b10
  } alu_cmd_t;

  localparam logic [1:0] TIPO_ILLEGAL = 2'b11;
  localparam logic [1:0] CMD_ILLEGAL  = 2'b11;

  // Bit positions inside the packed word; type-dependent fields overlap.
  localparam int unsigned TIPO_MSB = 16;
  localparam int unsigned TIPO_LSB = 15;
  localparam int unsigned I_BIT    = 14;
  localparam int unsigned CMD_MSB  = 13;
  localparam int unsigned CMD_LSB  = 12;
  localparam int unsigned L_BIT    = 12;
  localparam int unsigned B_BIT    = 14;
  localparam int unsigned COND_MSB = 13;
  localparam int unsigned COND_LSB = 11;
  localparam int unsigned OP_MSB   = 10;

endpackage : asip_isa_pkg

`default_nettype wire

// File: rtl/instr_packer.sv
// ============================================================================
// instr_packer : combinational field tuple -> 17-bit ASIP word plus illegal flag
// Revision     : 1.0
// ============================================================================
`default_nettype none

module instr_packer
  import asip_isa_pkg::*;
(
  input  logic [1:0]         tipo,
  input  logic               imm,
  input  logic [1:0]         cmd,
  input  logic               l,
  input  logic               b,
  input  logic [2:0]         cond,
  input  logic [OP_W-1:0]    operand,
  output logic [INSTR_W-1:0] word,
  output logic               illegal
);

  always_comb begin
    word                     = '0;
    illegal                  = 1'b0;
    word[TIPO_MSB:TIPO_LSB]  = tipo;
    word[OP_MSB:0]           = operand;
    case (tipo)
      TIPO_DATA: begin
        word[I_BIT]            = imm;
        word[CMD_MSB:CMD_LSB]  = cmd;
        illegal                = (cmd == CMD_ILLEGAL);
      end
      TIPO_MEM: begin
        word[L_BIT]            = l;
      end
      TIPO_BRANCH: begin
        word[B_BIT]            = b;
        word[COND_MSB:COND_LSB] = cond;
      end
      default: begin
        illegal                = 1'b1;
      end
    endcase
  end

endmodule : instr_packer

`default_nettype wire

// File: rtl/instr_encoder_loader.sv
// ============================================================================
// instr_encoder_loader : packs ASIP instruction tuples and writes them into IMEM
// Revision             : 1.0
// ============================================================================
`default_nettype none

module instr_encoder_loader
  import asip_isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_tipo,
  input  logic               in_i,
  input  logic [1:0]         in_cmd,
  input  logic               in_l,
  input  logic               in_b,
  input  logic [2:0]         in_cond,
  input  logic [OP_W-1:0]    in_operand,
  input  logic               in_last,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic [ADDR_W:0]    count,
  output logic               busy,
  output logic               done,
  output logic               err_illegal,
  output logic               err_overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  generate
    if (DEPTH > (1 << ADDR_W) || DEPTH < 1) begin : g_depth_check
      $error("instr_encoder_loader: DEPTH must be in 1..2**ADDR_W");
    end
  endgenerate

  logic [1:0]         state;
  logic               finish;
  logic               full;
  logic               accept;
  logic [INSTR_W-1:0] packed_word;
  logic               packed_illegal;

  instr_packer u_packer (
    .tipo    (in_tipo),
    .imm     (in_i),
    .cmd     (in_cmd),
    .l       (in_l),
    .b       (in_b),
    .cond    (in_cond),
    .operand (in_operand),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  // finish marks the cycle of the final write; the block stops accepting
  // then and moves to DONE on the following edge.
  assign full     = (count == DEPTH_C);
  assign in_ready = (state == S_LOAD) && !finish && !full;
  assign accept   = in_valid && in_ready && !start;
  assign busy     = (state == S_LOAD);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      finish       <= 1'b0;
      count        <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (start) begin
        state        <= S_LOAD;
        finish       <= 1'b0;
        count        <= '0;
        err_illegal  <= 1'b0;
        err_overflow <= 1'b0;
      end else begin
        if (accept) begin
          if (packed_illegal) begin
            err_illegal <= 1'b1;
            if (in_last) begin
              state <= S_DONE;
            end
          end else begin
            imem_we    <= 1'b1;
            imem_addr  <= count[ADDR_W-1:0];
            imem_wdata <= packed_word;
            count      <= count + 1'b1;
            if (in_last || ((count + 1'b1) == DEPTH_C)) begin
              finish <= 1'b1;
            end
          end
        end
        if (finish) begin
          state  <= S_DONE;
          finish <= 1'b0;
        end
        // Offers after the memory is full are flagged; offers to a block
        // that finished early via in_last are silently ignored.
        if (full && in_valid && (state != S_IDLE)) begin
          err_overflow <= 1'b1;
        end
      end
    end
  end

endmodule : instr_encoder_loader

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
// ============================================================================
// tb_instr_encoder_loader : directed bench for instr_encoder_loader
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_tipo = '0;
  logic        in_i = 1'b0;
  logic [1:0]  in_cmd = '0;
  logic        in_l = 1'b0;
  logic        in_b = 1'b0;
  logic [2:0]  in_cond = '0;
  logic [10:0] in_operand = '0;
  logic        in_last = 1'b0;

  logic        in_ready, imem_we, busy, done, err_illegal, err_overflow;
  logic [7:0]  imem_addr;
  logic [16:0] imem_wdata;
  logic [8:0]  count;

  logic        in_ready4, imem_we4, busy4, done4, err_illegal4, err_overflow4;
  logic [7:0]  imem_addr4;
  logic [16:0] imem_wdata4;
  logic [8:0]  count4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_tipo(in_tipo), .in_i(in_i), .in_cmd(in_cmd), .in_l(in_l), .in_b(in_b),
    .in_cond(in_cond), .in_operand(in_operand), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
    .busy(busy), .done(done), .err_illegal(err_illegal), .err_overflow(err_overflow)
  );

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
    .in_tipo(in_tipo), .in_i(in_i), .in_cmd(in_cmd), .in_l(in_l), .in_b(in_b),
    .in_cond(in_cond), .in_operand(in_operand), .in_last(in_last),
    .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4), .count(count4),
    .busy(busy4), .done(done4), .err_illegal(err_illegal4), .err_overflow(err_overflow4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] tipo, input logic i, input logic [1:0] cmd,
                       input logic l, input logic b, input logic [2:0] cond,
                       input logic [10:0] op, input logic last);
    in_valid   = 1'b1;
    in_tipo    = tipo;
    in_i       = i;
    in_cmd     = cmd;
    in_l       = l;
    in_b       = b;
    in_cond    = cond;
    in_operand = op;
    in_last    = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_ill", err_illegal, 0);
    chk("rst_err_ovf", err_overflow, 0);
    reset = 1'b0;
    tick();

    // Single ADD-immediate
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_ready", in_ready, 1);
    drive(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 11'h005, 1'b0);
    tick();
    idle_in();
    chk("t1_we", imem_we, 1);
    chk("t1_addr", imem_addr, 0);
    chk("t1_wdata", imem_wdata, 17'h04005);
    chk("t1_count", count, 1);
    tick();
    chk("t1_we_low", imem_we, 0);

    // LDR, STR, B(last) back-to-back
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 3'b000, 11'h010, 1'b0);
    tick();
    chk("t2_we0", imem_we, 1);
    chk("t2_addr0", imem_addr, 0);
    chk("t2_wdata0", imem_wdata, 17'h09010);
    drive(2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 11'h020, 1'b0);
    tick();
    chk("t2_we1", imem_we, 1);
    chk("t2_addr1", imem_addr, 1);
    chk("t2_wdata1", imem_wdata, 17'h08020);
    drive(2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 3'b101, 11'h7FF, 1'b1);
    tick();
    idle_in();
    chk("t2_we2", imem_we, 1);
    chk("t2_addr2", imem_addr, 2);
    chk("t2_wdata2", imem_wdata, 17'h16FFF);
    chk("t2_done_early", done, 0);
    tick();
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 0);
    chk("t2_count", count, 3);
    chk("t2_we_low", imem_we, 0);

    // Illegal tuples dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 11'h001, 1'b0);
    tick();
    chk("t3_we_a", imem_we, 0);
    chk("t3_err_ill", err_illegal, 1);
    chk("t3_count_a", count, 0);
    drive(2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 3'b000, 11'h002, 1'b0);
    tick();
    chk("t3_we_b", imem_we, 0);
    chk("t3_count_b", count, 0);
    drive(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 11'h123, 1'b0);
    tick();
    chk("t3_we_c", imem_we, 1);
    chk("t3_addr_c", imem_addr, 0);
    chk("t3_wdata_c", imem_wdata, 17'h00123);
    drive(2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 11'h000, 1'b1);
    tick();
    chk("t3_ill_last_done", done, 1);
    chk("t3_ill_last_we", imem_we, 0);
    chk("t3_ill_last_count", count, 1);

    // start with in_valid in DONE: start wins
    start = 1'b1;
    drive(2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 3'b000, 11'h3AA, 1'b0);
    tick();
    start = 1'b0;
    idle_in();
    chk("t4_count", count, 0);
    chk("t4_done", done, 0);
    chk("t4_busy", busy, 1);
    chk("t4_we", imem_we, 0);
    chk("t4_err_ill", err_illegal, 0);

    // Reset during third write of a six-word load
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 11'(k), 1'b0);
      tick();
      chk("t5_addr", imem_addr, k);
    end
    reset = 1'b1;
    #2;
    chk("t5_rst_we", imem_we, 0);
    chk("t5_rst_addr", imem_addr, 0);
    chk("t5_rst_wdata", imem_wdata, 0);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", in_ready, 0);
    tick();
    idle_in();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 3'b000, 11'h055, 1'b0);
    tick();
    idle_in();
    chk("t5_reload_we", imem_we, 1);
    chk("t5_reload_addr", imem_addr, 0);
    chk("t5_reload_wdata", imem_wdata, 17'h09055);

    // Overflow on the DEPTH=4 instance
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 3'b000, 11'(k), 1'b0);
      chk("t6_ready", in_ready4, (k < 4) ? 1 : 0);
      tick();
      if (k < 4) begin
        chk("t6_we", imem_we4, 1);
        chk("t6_addr", imem_addr4, k);
      end else begin
        chk("t6_we_full", imem_we4, 0);
        chk("t6_addr_hold", imem_addr4, 3);
        chk("t6_err_ovf", err_overflow4, 1);
        chk("t6_done", done4, 1);
      end
    end
    idle_in();
    tick();
    chk("t6_count", count4, 4);
    chk("t6_we_idle", imem_we4, 0);
    chk("t6_main_no_ovf", err_overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule : tb_instr_encoder_loader

`default_nettype wire
